// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and counter sizing.
package uart_pkg;

   localparam int DATA_BITS = 8;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] POP   = 3'd1;
   localparam logic [2:0] WAIT  = 3'd2;
   localparam logic [2:0] START = 3'd3;
   localparam logic [2:0] DATA  = 3'd4;
   localparam logic [2:0] STOP  = 3'd5;

   // Width of a counter that must hold 0..clks_per_bit-1 (at least one bit).
   function automatic int cnt_width(input int clks_per_bit);
      return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
   endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the keyboard byte FIFO and its consumer.
interface fifo_uart_tx_if;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_rd_en;

   // master: the reader that pops bytes; slave: the FIFO itself
   modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
   modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/baud_cnt.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while run is high, held at 0 otherwise.
// bit_pre_end lets a caller register a strobe that lands on the last cycle of a bit.
module baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic bit_end,
   output logic bit_pre_end
);

   localparam int W = cnt_width(CLKS_PER_BIT);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
   localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

   logic [W-1:0] cnt;

   // Free-run within a bit period, wrap on the boundary, park at zero when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!run || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

   assign bit_end     = run && (cnt == LAST);
   assign bit_pre_end = run && (cnt == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the keyboard byte FIFO onto an 8N1 UART line, LSB first.
//
// state | meaning
// IDLE  | line high, waiting for a byte and tx_en
// POP   | one-cycle FIFO read strobe
// WAIT  | FIFO data valid, load shift register
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high), tx_done on its last cycle
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = 50000000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic              clk,
   input  logic              rst_n,
   fifo_uart_tx_if.master    fifo,
   input  logic              tx_en,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   logic [2:0]           state;
   logic [DATA_BITS-1:0] shift;
   logic [2:0]           bit_cnt;
   logic                 run;
   logic                 bit_end;
   logic                 bit_pre_end;

   assign run = (state == START) || (state == DATA) || (state == STOP);

   baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .bit_end     (bit_end),
      .bit_pre_end (bit_pre_end)
   );

   // Sequencer: every output is loaded with the value it must show in the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         shift           <= '0;
         bit_cnt         <= '0;
         tx              <= 1'b1;
         busy            <= 1'b0;
         tx_done         <= 1'b0;
         fifo.fifo_rd_en <= 1'b0;
      end else begin
         fifo.fifo_rd_en <= 1'b0;
         tx_done         <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo.fifo_empty && tx_en) begin
                  state           <= POP;
                  fifo.fifo_rd_en <= 1'b1;
                  busy            <= 1'b1;
               end
            end
            POP: begin
               state <= WAIT;
            end
            WAIT: begin
               shift <= fifo.fifo_data;
               tx    <= 1'b0;
               state <= START;
            end
            START: begin
               if (bit_end) begin
                  tx    <= shift[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt == 3'(DATA_BITS - 1)) begin
                     tx      <= 1'b1;
                     bit_cnt <= '0;
                     state   <= STOP;
                  end else begin
                     // next bit is shift[1]; present it as the shift happens
                     shift   <= {1'b0, shift[DATA_BITS-1:1]};
                     tx      <= shift[1];
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            STOP: begin
               if (bit_pre_end) begin
                  tx_done <= 1'b1;
               end
               if (bit_end) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               tx      <= 1'b1;
               busy    <= 1'b0;
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed + random bench for fifo_uart_tx with a FIFO model and a UART receiver model.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic tx_en;
   logic tx;
   logic busy;
   logic tx_done;

   fifo_uart_tx_if bus ();

   fifo_uart_tx #(
      .CLK_FREQ     (50000000),
      .BAUD         (115200),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .fifo    (bus),
      .tx_en   (tx_en),
      .tx      (tx),
      .busy    (busy),
      .tx_done (tx_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pops = 0;
   int dones = 0;
   int starts = 0;
   int rx_cnt = 0;
   int fstart = 0;
   int last_done = 0;
   bit in_frame = 0;
   bit prev_done = 0;
   bit b2b_chk = 0;
   logic prev_tx = 1'b1;
   logic txen_before;
   logic [9:0] frame_bits;
   logic [7:0] q[$];
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      q.push_back(b);
      exp_q.push_back(b);
      bus.fifo_empty = 1'b0;
   endtask

   // One clock: service the FIFO model and run the line receiver model.
   task automatic tick();
      int off;
      txen_before = tx_en;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.fifo_rd_en) begin
         pops++;
         check("pop_nonempty", 32'(q.size() != 0), 1);
         check("pop_txen", 32'(txen_before), 1);
         if (q.size() != 0) bus.fifo_data = q.pop_front();
      end
      bus.fifo_empty = (q.size() == 0);
      if (prev_done) check("busy_fall", 32'(busy), 0);
      prev_done = tx_done;
      if (tx_done) begin
         dones++;
         if (!in_frame) check("done_in_frame", 32'(in_frame), 1);
      end
      if (in_frame) begin
         off = cyc - fstart;
         if (off % CPB == CPB / 2) frame_bits[off / CPB] = tx;
         if (tx_done) check("done_pos", off, 10 * CPB - 1);
         if (off == 10 * CPB - 1) begin
            in_frame = 0;
            rx_cnt++;
            last_done = cyc;
            check("start_bit", 32'(frame_bits[0]), 0);
            check("stop_bit", 32'(frame_bits[9]), 1);
            check("rx_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("rx_byte", 32'(frame_bits[8:1]), 32'(exp_q.pop_front()));
         end
      end else if (prev_tx === 1'b1 && tx === 1'b0) begin
         in_frame = 1;
         fstart = cyc;
         starts++;
         frame_bits = '0;
         if (b2b_chk) check("line_high_gap", cyc - last_done + CPB - 1, CPB + 3);
      end
      prev_tx = tx;
   endtask

   task automatic wait_rx(input int target, input int budget);
      int n = 0;
      while (rx_cnt < target && n < budget) begin
         tick();
         n++;
      end
      check("wait_rx", rx_cnt, target);
   endtask

   task automatic wait_start(input int budget);
      int s0 = starts;
      int n = 0;
      while (starts == s0 && n < budget) begin
         tick();
         n++;
      end
      check("wait_start", starts, s0 + 1);
   endtask

   initial begin
      int p0;
      int s0;
      int target;
      int pushed;
      int n;

      rst_n = 1'b0;
      tx_en = 1'b1;
      bus.fifo_empty = 1'b1;
      bus.fifo_data = 8'h00;

      // 1: held in reset with an empty FIFO
      repeat (50) begin
         tick();
         check("rst_tx", 32'(tx), 1);
         check("rst_busy", 32'(busy), 0);
         check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
      end
      rst_n = 1'b1;
      repeat (10) tick();
      check("idle_no_pop", pops, 0);
      check("idle_tx", 32'(tx), 1);

      // 2: single byte, latency and frame shape
      push(8'hA5);
      tick();
      check("t2_pop", 32'(bus.fifo_rd_en), 1);
      check("t2_busy", 32'(busy), 1);
      tick();
      check("t2_pop_single", 32'(bus.fifo_rd_en), 0);
      check("t2_tx_wait", 32'(tx), 1);
      tick();
      check("t2_start_lat", 32'(tx), 0);
      check("t2_starts", starts, 1);
      wait_rx(1, 100);
      repeat (5) tick();
      check("t2_pops", pops, 1);
      check("t2_dones", dones, 1);

      // 3: three queued bytes back to back
      p0 = pops;
      push(8'h00);
      push(8'hFF);
      push(8'h3C);
      wait_start(20);
      b2b_chk = 1;
      wait_rx(rx_cnt + 3, 300);
      b2b_chk = 0;
      check("t3_pops", pops, p0 + 3);
      repeat (30) tick();
      check("t3_no_extra_pop", pops, p0 + 3);

      // 4: flow control
      p0 = pops;
      tx_en = 1'b0;
      push(8'h81);
      repeat (30) tick();
      check("t4_held_pops", pops, p0);
      check("t4_held_tx", 32'(tx), 1);
      tx_en = 1'b1;
      tick();
      check("t4_pop", 32'(bus.fifo_rd_en), 1);
      tick();
      tick();
      check("t4_start_lat", 32'(tx), 0);
      repeat (20) tick();
      tx_en = 1'b0;
      push(8'h7E);
      wait_rx(rx_cnt + 1, 100);
      repeat (40) tick();
      check("t4_no_pop_after", pops, p0 + 1);
      tx_en = 1'b1;
      wait_rx(rx_cnt + 1, 200);
      check("t4_drained", pops, p0 + 2);

      // 5: reset during data bit 3
      push(8'h55);
      wait_start(20);
      repeat (17) tick();
      rst_n = 1'b0;
      #1;
      check("t5_async_tx", 32'(tx), 1);
      check("t5_async_busy", 32'(busy), 0);
      in_frame = 0;
      while (exp_q.size() > q.size()) void'(exp_q.pop_front());
      repeat (3) tick();
      rst_n = 1'b1;
      p0 = pops;
      s0 = starts;
      repeat (60) tick();
      check("t5_no_pop", pops, p0);
      check("t5_no_frame", starts, s0);
      check("t5_tx_idle", 32'(tx), 1);

      // 6: random bytes with random flow control
      p0 = pops;
      target = rx_cnt + 200;
      pushed = 0;
      n = 0;
      while (rx_cnt < target && n < 40000) begin
         if (pushed < 200 && $urandom_range(0, 7) == 0) begin
            push(8'($urandom_range(0, 255)));
            pushed++;
         end
         if ($urandom_range(0, 15) == 0) tx_en = ~tx_en;
         tick();
         n++;
      end
      check("t6_frames", rx_cnt, target);
      check("t6_pops", pops, p0 + 200);
      check("t6_stream_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
